// File: rtl/wake_pkg.sv
// Shared types and default dimensions for the issue-stage wake broadcaster.
package wake_pkg;

  localparam int DEF_SRC_NUM    = 6;
  localparam int DEF_BCAST_NUM  = 4;
  localparam int DEF_COMMIT_NUM = 2;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int PREG_WIDTH     = 7;
  localparam int DATA_WIDTH     = 32;
  localparam int SRC_BITS       = PREG_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic [PREG_WIDTH-1:0] dst;
    logic [DATA_WIDTH-1:0] data;
  } wake_src_t;

  typedef struct packed {
    logic                  valid;
    logic [PREG_WIDTH-1:0] dst;
  } wake_req_t;

  typedef struct packed {
    logic                  valid;
    logic [PREG_WIDTH-1:0] dst;
    logic [DATA_WIDTH-1:0] data;
  } bcast_t;

endpackage

// File: rtl/wake_fifo.sv
// Per-source circular buffer of completion results with occupancy count and flush clear.
module wake_fifo
  import wake_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                push,
  input  logic [SRC_BITS-1:0] wdata,
  input  logic                pop,
  output logic [SRC_BITS-1:0] rdata,
  output logic                empty,
  output logic                ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SRC_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    count_q;

  // NOTE: storage is left unreset; only pointers and count carry meaning after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign ready = (count_q != CNT_W'(DEPTH));

endmodule

// File: rtl/wake_broadcaster.sv
// Buffers execute completions per source, round-robin arbitrates them onto the broadcast
// ports and registers execute/commit wakes. Define WAKE_BYPASS_EN to let requests that
// arrive at an empty buffer compete for a port in their arrival cycle.
module wake_broadcaster
  import wake_pkg::*;
#(
  parameter int SRC_NUM    = DEF_SRC_NUM,
  parameter int BCAST_NUM  = DEF_BCAST_NUM,
  parameter int COMMIT_NUM = DEF_COMMIT_NUM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             flush,
  input  logic [SRC_NUM-1:0]               src_valid,
  input  logic [SRC_NUM*PREG_WIDTH-1:0]    src_dst,
  input  logic [SRC_NUM*DATA_WIDTH-1:0]    src_data,
  output logic [SRC_NUM-1:0]               src_ready,
  input  logic [COMMIT_NUM-1:0]            commit_valid,
  input  logic [COMMIT_NUM*PREG_WIDTH-1:0] commit_dst,
  output logic [BCAST_NUM-1:0]             bc_valid,
  output logic [BCAST_NUM*PREG_WIDTH-1:0]  bc_dst,
  output logic [BCAST_NUM*DATA_WIDTH-1:0]  bc_data,
  output logic [COMMIT_NUM-1:0]            wc_valid,
  output logic [COMMIT_NUM*PREG_WIDTH-1:0] wc_dst
);

  localparam int RR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

  wake_src_t          src_in [SRC_NUM];
  wake_src_t          head   [SRC_NUM];
  wake_src_t          cand   [SRC_NUM];
  logic [SRC_NUM-1:0] empty, req, grant, push, pop;
  logic [RR_W-1:0]    rr_q, rr_d;
  bcast_t             bc_d [BCAST_NUM];
  bcast_t             bc_q [BCAST_NUM];
  wake_req_t          wc_q [COMMIT_NUM];

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    wake_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .push   (push[i]),
      .wdata  (src_in[i]),
      .pop    (pop[i]),
      .rdata  (head[i]),
      .empty  (empty[i]),
      .ready  (src_ready[i])
    );
  end

  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      src_in[i] = '{dst: src_dst[i*PREG_WIDTH +: PREG_WIDTH],
                    data: src_data[i*DATA_WIDTH +: DATA_WIDTH]};
      req[i]    = !empty[i];
      cand[i]   = head[i];
`ifdef WAKE_BYPASS_EN
      // Only an empty buffer may bypass, so per-source order is preserved.
      if (empty[i] && src_valid[i]) begin
        req[i]  = 1'b1;
        cand[i] = src_in[i];
      end
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin : arb
    int n_grant;
    n_grant = 0;
    grant   = '0;
    rr_d    = rr_q;
    for (int p = 0; p < BCAST_NUM; p++) bc_d[p] = '0;
    // Walk sources in rotated order; only the rotation matching rr_q is live.
    for (int k = 0; k < SRC_NUM; k++) begin
      for (int r = 0; r < SRC_NUM; r++) begin
        if (int'(rr_q) == r && req[(r + k) % SRC_NUM] && n_grant < BCAST_NUM) begin
          grant[(r + k) % SRC_NUM] = 1'b1;
          for (int p = 0; p < BCAST_NUM; p++) begin
            if (p == n_grant) begin
              bc_d[p] = '{valid: 1'b1,
                          dst:   cand[(r + k) % SRC_NUM].dst,
                          data:  cand[(r + k) % SRC_NUM].data};
            end
          end
          rr_d    = RR_W'((r + k + 1) % SRC_NUM);
          n_grant = n_grant + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      pop[i]  = grant[i] & !empty[i];
      push[i] = src_valid[i] & src_ready[i] & !flush & !(grant[i] & empty[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q <= '0;
      for (int p = 0; p < BCAST_NUM; p++)  bc_q[p] <= '0;
      for (int c = 0; c < COMMIT_NUM; c++) wc_q[c] <= '0;
    end else begin
      for (int c = 0; c < COMMIT_NUM; c++) begin
        wc_q[c] <= '{valid: commit_valid[c], dst: commit_dst[c*PREG_WIDTH +: PREG_WIDTH]};
      end
      if (flush) begin
        rr_q <= '0;
        for (int p = 0; p < BCAST_NUM; p++) bc_q[p] <= '0;
      end else begin
        rr_q <= rr_d;
        for (int p = 0; p < BCAST_NUM; p++) bc_q[p] <= bc_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < BCAST_NUM; p++) begin
      bc_valid[p]                           = bc_q[p].valid;
      bc_dst[p*PREG_WIDTH +: PREG_WIDTH]    = bc_q[p].dst;
      bc_data[p*DATA_WIDTH +: DATA_WIDTH]   = bc_q[p].data;
    end
    for (int c = 0; c < COMMIT_NUM; c++) begin
      wc_valid[c]                           = wc_q[c].valid;
      wc_dst[c*PREG_WIDTH +: PREG_WIDTH]    = wc_q[c].dst;
    end
  end

endmodule
